// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 receive monitor: FSM states,
// bus field widths and the capture-memory address packing.
package hub75_pkg;

   localparam int ROW_W   = 5;
   localparam int X_W     = 9;
   localparam int PLANE_W = 3;
   localparam int RGB_W   = 6;
   localparam int ADDR_W  = ROW_W + X_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_e;

   function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [X_W-1:0]   x);
      return {row, x};
   endfunction

endpackage

// File: rtl/hub75_in_sync.sv
// Multi-bit 2-FF synchroniser with a history stage and rising-edge outputs.
// All bits share one pipeline, so they stay mutually aligned.
module hub75_in_sync #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] async_i,
   output logic [W-1:0] sync_o,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;
   logic [W-1:0] hist_q;

   // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         hist_q <= RST_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_o = sync_q & ~hist_q;

endmodule

// File: rtl/hub75_rx_monitor.sv
// HUB75 panel-side receiver: rebuilds row/plane pixel writes and flags protocol errors.
// Optional OE on-time measurement is built when HUB75_RX_OE_MEASURE_EN is defined.
module hub75_rx_monitor
   import hub75_pkg::*;
#(
   parameter int NUM_ROWS       = 32,
   parameter int PLANE_MAX      = 7,
   parameter int PLANE_MIN      = 2,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int OE_CNT_W       = 20
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                enable,
   input  logic [9:0]          pixels_per_row,
   input  logic                hub_clk,
   input  logic                hub_lat,
   input  logic                hub_oe,
   input  logic [ROW_W-1:0]    hub_abcde,
   input  logic [RGB_W-1:0]    hub_rgb,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [RGB_W-1:0]    wr_data,
   output logic [PLANE_W-1:0]  wr_plane,
   output logic                row_done,
   output logic                row_err,
   output logic                frame_done,
   output logic                sync_lost,
   output logic [OE_CNT_W-1:0] oe_width,
   output logic                oe_width_valid
);

   localparam int BUS_W = 3 + ROW_W + RGB_W;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(NUM_ROWS - 1);
   localparam logic [PLANE_W-1:0] P_MAX    = PLANE_W'(PLANE_MAX);
   localparam logic [PLANE_W-1:0] P_MIN    = PLANE_W'(PLANE_MIN);
   // OE idles high (panel dark), so its synchroniser leaves reset high to avoid a phantom edge.
   localparam logic [BUS_W-1:0]   SYNC_RST = {3'b001, {ROW_W{1'b0}}, {RGB_W{1'b0}}};

   logic [BUS_W-1:0] bus_s, bus_rise;
   logic             clk_rise, lat_rise;
   logic [ROW_W-1:0] abcde_s;
   logic [RGB_W-1:0] rgb_s;
   logic             unused_sync;

   hub75_in_sync #(.W(BUS_W), .RST_VAL(SYNC_RST)) u_sync (
      .clk     (clk),
      .resetn  (resetn),
      .async_i ({hub_clk, hub_lat, hub_oe, hub_abcde, hub_rgb}),
      .sync_o  (bus_s),
      .rise_o  (bus_rise)
   );

   assign clk_rise    = bus_rise[BUS_W-1];
   assign lat_rise    = bus_rise[BUS_W-2];
   assign abcde_s     = bus_s[ROW_W+RGB_W-1:RGB_W];
   assign rgb_s       = bus_s[RGB_W-1:0];
   assign unused_sync = ^{bus_s[BUS_W-1:BUS_W-2], bus_rise[ROW_W+RGB_W-1:0]};

   state_e              state_q, state_d;
   logic [X_W:0]        x_q, x_d;
   logic [3:0]          ovf_q, ovf_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [PLANE_W-1:0]  plane_q, plane_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [RGB_W-1:0]    wr_data_q, wr_data_d;
   logic [PLANE_W-1:0]  wr_plane_q, wr_plane_d;
   logic                row_done_q, row_done_d, row_err_q, row_err_d;
   logic                frame_done_q, frame_done_d, sync_lost_q, sync_lost_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         x_q          <= '0;
         ovf_q        <= '0;
         row_q        <= '0;
         plane_q      <= P_MAX;
         to_q         <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         wr_plane_q   <= '0;
         row_done_q   <= 1'b0;
         row_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
         sync_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         ovf_q        <= ovf_d;
         row_q        <= row_d;
         plane_q      <= plane_d;
         to_q         <= to_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         wr_plane_q   <= wr_plane_d;
         row_done_q   <= row_done_d;
         row_err_q    <= row_err_d;
         frame_done_q <= frame_done_d;
         sync_lost_q  <= sync_lost_d;
      end
   end

   // NOTE: every _d gets a default before any branch, so this block cannot infer a latch.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      ovf_d        = ovf_q;
      row_d        = row_q;
      plane_d      = plane_q;
      to_d         = '0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      wr_plane_d   = wr_plane_q;
      row_done_d   = 1'b0;
      row_err_d    = 1'b0;
      frame_done_d = 1'b0;
      sync_lost_d  = 1'b0;

      if (!enable) begin
         state_d = IDLE;
         x_d     = '0;
         ovf_d   = '0;
         row_d   = '0;
         plane_d = P_MAX;
      end else begin
         case (state_q)
            IDLE: begin
               if (clk_rise) begin
                  wr_en_d    = 1'b1;
                  wr_addr_d  = pack_addr(row_q, '0);
                  wr_data_d  = rgb_s;
                  wr_plane_d = plane_q;
                  x_d        = (X_W+1)'(1);
                  state_d    = SHIFT;
               end
            end
            SHIFT, LATCH: begin
               to_d = (clk_rise || lat_rise) ? '0 : to_q + 1'b1;
               if (state_q == SHIFT) begin
                  // A same-sample clock and latch writes the pixel here, then LATCH sees the final x.
                  if (clk_rise) begin
                     if (x_q < pixels_per_row) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = pack_addr(row_q, x_q[X_W-1:0]);
                        wr_data_d  = rgb_s;
                        wr_plane_d = plane_q;
                        x_d        = x_q + 1'b1;
                     end else if (ovf_q != '1) begin
                        ovf_d = ovf_q + 1'b1;
                     end
                  end
                  if (lat_rise) state_d = LATCH;
               end else begin
                  row_done_d = 1'b1;
                  row_err_d  = (x_q != pixels_per_row) || (ovf_q != '0) || (abcde_s != row_q);
                  x_d        = '0;
                  ovf_d      = '0;
                  row_d      = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                  if (row_q == ROW_LAST) begin
                     if (plane_q == P_MIN) begin
                        plane_d      = P_MAX;
                        frame_done_d = 1'b1;
                     end else begin
                        plane_d = plane_q - 1'b1;
                     end
                  end
                  state_d = SHIFT;
               end
               if (!clk_rise && !lat_rise && to_q == TO_LAST) begin
                  sync_lost_d  = 1'b1;
                  state_d      = IDLE;
                  x_d          = '0;
                  ovf_d        = '0;
                  row_d        = '0;
                  plane_d      = P_MAX;
                  to_d         = '0;
                  row_done_d   = 1'b0;
                  row_err_d    = 1'b0;
                  frame_done_d = 1'b0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign wr_plane   = wr_plane_q;
   assign row_done   = row_done_q;
   assign row_err    = row_err_q;
   assign frame_done = frame_done_q;
   assign sync_lost  = sync_lost_q;

`ifdef HUB75_RX_OE_MEASURE_EN
   logic [OE_CNT_W-1:0] oe_cnt_q, oe_cnt_d, oe_width_q, oe_width_d;
   logic                oe_valid_q, oe_valid_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         oe_cnt_q   <= '0;
         oe_width_q <= '0;
         oe_valid_q <= 1'b0;
      end else begin
         oe_cnt_q   <= oe_cnt_d;
         oe_width_q <= oe_width_d;
         oe_valid_q <= oe_valid_d;
      end
   end

   always_comb begin
      oe_cnt_d   = oe_cnt_q;
      oe_width_d = oe_width_q;
      oe_valid_d = 1'b0;
      if (!enable) begin
         oe_cnt_d = '0;
      end else if (bus_rise[ROW_W+RGB_W]) begin
         oe_width_d = oe_cnt_q;
         oe_valid_d = 1'b1;
         oe_cnt_d   = '0;
      end else if (!bus_s[ROW_W+RGB_W] && oe_cnt_q != '1) begin
         oe_cnt_d = oe_cnt_q + 1'b1;
      end
   end

   assign oe_width       = oe_width_q;
   assign oe_width_valid = oe_valid_q;
`else
   logic unused_oe;
   assign unused_oe      = bus_s[ROW_W+RGB_W] ^ bus_rise[ROW_W+RGB_W];
   assign oe_width       = '0;
   assign oe_width_valid = 1'b0;
`endif

endmodule
